// File: rtl/operand2_pipe.sv
// operand2_pipe: SPARC second-operand decoder feeding a DEPTH-entry valid/ready FIFO
module operand2_pipe #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_rs2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_class
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [1:0] op;
  logic [2:0] op2;
  logic [5:0] op3;
  logic i, shift, push, pop;
  logic [2:0] cls;
  logic [DATA_W-1:0] dat;
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [2:0] mem_c [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  assign op = in_instr[31:30];
  assign op2 = in_instr[24:22];
  assign op3 = in_instr[24:19];
  assign i = in_instr[13];
  assign shift = op3 == 6'b100101 || op3 == 6'b100110 || op3 == 6'b100111;
  always_comb begin
    cls = op == 2'b01 ? 3'd6 :
          op == 2'b00 ? (op2 == 3'b100 ? 3'd4 : 3'd5) :
          (op == 2'b10 && shift) ? (i ? 3'd3 : 3'd2) :
          (i ? 3'd1 : 3'd0);
    dat = cls == 3'd6 ? (DATA_W'(signed'(in_instr[29:0])) << 2) :
          cls == 3'd4 ? DATA_W'({in_instr[21:0], 10'b0}) :
          cls == 3'd5 ? (DATA_W'(signed'(in_instr[21:0])) << 2) :
          cls == 3'd2 ? DATA_W'(in_rs2[4:0]) :
          cls == 3'd3 ? DATA_W'(in_instr[4:0]) :
          cls == 3'd1 ? DATA_W'(signed'(in_instr[12:0])) :
          in_rs2;
  end
  assign in_ready = count != CW'(DEPTH);
  assign out_valid = count != '0;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign out_data = out_valid ? mem_d[rptr] : '0;
  assign out_class = out_valid ? mem_c[rptr] : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      wptr <= '0;
      rptr <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        mem_d[k] <= '0;
        mem_c[k] <= '0;
      end
    end else if (flush) begin
      count <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) begin
        mem_d[wptr] <= dat;
        mem_c[wptr] <= cls;
        wptr <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_operand2_pipe.sv
// tb_operand2_pipe: randomized scoreboard bench running 32- and 64-bit instances in lockstep
module tb_operand2_pipe;
  localparam int DEPTH = 2;
  typedef struct {
    logic [63:0] d;
    logic [2:0]  c;
  } exp_t;
  logic clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_instr = '0, in_rs2 = '0;
  logic [63:0] rs2_64 = '0;
  logic in_ready, out_valid, in_ready64, out_valid64;
  logic [31:0] out_data;
  logic [63:0] out_data64;
  logic [2:0] out_class, out_class64;
  exp_t q[$];
  int compared = 0, mismatched = 0;
  logic acc;
  operand2_pipe #(.DATA_W(32), .DEPTH(DEPTH)) u32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_rs2(in_rs2), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_class(out_class));
  operand2_pipe #(.DATA_W(64), .DEPTH(DEPTH)) u64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_rs2(rs2_64), .out_valid(out_valid64), .out_ready(out_ready),
    .out_data(out_data64), .out_class(out_class64));
  always #5 clk = ~clk;
  // Reference decode at 64 bits; the 32-bit result is its low half in every class.
  function automatic exp_t model(input logic [31:0] ins, input logic [63:0] r);
    exp_t e;
    longint v;
    int c;
    logic [5:0] op3;
    op3 = ins[24:19];
    if (ins[31:30] == 2'b01) begin
      c = 6;
      v = longint'($signed(ins[29:0])) * 4;
    end else if (ins[31:30] == 2'b00) begin
      if (ins[24:22] == 3'b100) begin
        c = 4;
        v = longint'(ins[21:0]) * 1024;
      end else begin
        c = 5;
        v = longint'($signed(ins[21:0])) * 4;
      end
    end else if (ins[31:30] == 2'b10 && op3 inside {6'b100101, 6'b100110, 6'b100111}) begin
      c = ins[13] ? 3 : 2;
      v = ins[13] ? longint'(ins[4:0]) : longint'(r[4:0]);
    end else begin
      c = ins[13] ? 1 : 0;
      v = ins[13] ? longint'($signed(ins[12:0])) : longint'(r);
    end
    e.d = v;
    e.c = c[2:0];
    return e;
  endfunction
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      chk("out_valid", {63'b0, out_valid}, {63'b0, q.size() != 0});
      chk("in_ready", {63'b0, in_ready}, {63'b0, q.size() != DEPTH});
      chk("out_valid64", {63'b0, out_valid64}, {63'b0, q.size() != 0});
      chk("in_ready64", {63'b0, in_ready64}, {63'b0, q.size() != DEPTH});
      if (q.size() != 0) begin
        chk("data32", {32'b0, out_data}, {32'b0, q[0].d[31:0]});
        chk("class32", {61'b0, out_class}, {61'b0, q[0].c});
        chk("data64", out_data64, q[0].d);
        chk("class64", {61'b0, out_class64}, {61'b0, q[0].c});
        if (out_valid && out_ready && !flush) void'(q.pop_front());
      end else begin
        chk("empty_data32", {32'b0, out_data}, 64'd0);
        chk("empty_class32", {61'b0, out_class}, 64'd0);
        chk("empty_data64", out_data64, 64'd0);
      end
    end
  end
  task automatic cyc(input logic v, input logic [31:0] ins, input logic [63:0] r,
                     input logic ordy, input logic fl, input logic rst, output logic a);
    in_valid = v;
    in_instr = ins;
    in_rs2 = r[31:0];
    rs2_64 = r;
    out_ready = ordy;
    flush = fl;
    reset = rst;
    @(negedge clk);
    a = v && in_ready && !fl && !rst;
    @(posedge clk);
    #1;
    if (rst || fl) q.delete();
    else if (a) q.push_back(model(ins, r));
  endtask
  task automatic send(input logic [31:0] ins, input logic [63:0] r, input logic ordy);
    logic a;
    for (int n = 0; n < 20; n++) begin
      cyc(1, ins, r, ordy, 0, 0, a);
      if (a) return;
    end
    mismatched++;
    $display("FAIL send_timeout: got not accepted expected accepted");
  endtask
  task automatic idle(input int n, input logic ordy);
    logic a;
    for (int k = 0; k < n; k++) cyc(0, $urandom, {$urandom, $urandom}, ordy, 0, 0, a);
  endtask
  initial begin
    logic [31:0] ins;
    @(posedge clk);
    #1;
    cyc(1, 32'h40000001, 64'd0, 1, 0, 1, acc);
    cyc(0, 32'h0, 64'd0, 1, 0, 1, acc);
    idle(2, 1);
    send(32'h03000ABC, 64'd0, 1);
    send(32'h40000001, 64'd0, 1);
    send(32'h10BFFFFF, 64'd0, 1);
    send(32'h80003FFF, 64'd0, 1);
    send(32'h80000000, 64'hCAFEF00D_DEADBEEF, 1);
    send(32'h81280000, 64'hFFFFFFFF_FFFFFFE7, 1);
    send(32'h8138201F, 64'd0, 1);
    send(32'h80003000, 64'd0, 1);
    send(32'h013FFFFF, 64'd0, 1);
    idle(3, 1);
    // three pushes against a stalled consumer; the third must wait for space
    cyc(1, 32'h40000010, 64'd0, 0, 0, 0, acc);
    cyc(1, 32'h40000020, 64'd0, 0, 0, 0, acc);
    for (int k = 0; k < 4; k++) cyc(1, 32'h40000030, 64'd0, 0, 0, 0, acc);
    send(32'h40000030, 64'd0, 1);
    idle(3, 1);
    cyc(1, 32'h80002001, 64'd0, 0, 0, 0, acc);
    for (int k = 0; k < 8; k++) send(32'h80002100 + k, 64'd0, 1);
    idle(3, 1);
    // flush with a full buffer and a same-cycle push
    send(32'h80002011, 64'd0, 0);
    send(32'h80002012, 64'd0, 0);
    cyc(1, 32'h80002013, 64'd0, 1, 1, 0, acc);
    idle(2, 1);
    send(32'h80002021, 64'd0, 0);
    send(32'h80002022, 64'd0, 0);
    cyc(1, 32'h80002023, 64'd0, 1, 0, 1, acc);
    idle(2, 1);
    for (int k = 0; k < 400; k++) begin
      ins = $urandom;
      if ($urandom_range(3) == 0) ins = {2'b10, ins[29:25], 3'b100, 1'b1, ins[18:0]} ^ {8'b0, ($urandom_range(2) == 0) ? 1'b1 : 1'b0, 23'b0};
      cyc($urandom_range(3) != 0, ins, {$urandom, $urandom}, $urandom_range(3) != 0,
          $urandom_range(39) == 0, $urandom_range(149) == 0, acc);
    end
    idle(6, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
